// File: rtl/joystick_conditioner.sv
// Conditions raw active-low Pmod joystick pins: synchronise, debounce, optional
// autofire on fire, port swap, and a registered active-high output with change strobe.
module joystick_conditioner #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PRESCALE       = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 8,
  parameter int unsigned AUTOFIRE_HALF  = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [0:4] joya_raw,
  input  logic [0:4] joyb_raw,
  input  logic [1:0] autofire_en,
  input  logic       swap,
  output logic [0:4] joy1,
  output logic [0:4] joy2,
  output logic       changed
);

  localparam int unsigned NB   = 10;
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int unsigned AF_W = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

  logic [NB-1:0]                   raw;
  logic [SYNC_STAGES-1:0][NB-1:0]  sync_q;
  logic [NB-1:0]                   sync;
  logic [PS_W-1:0]                 ps_q, ps_d;
  logic                            tick;
  logic [NB-1:0]                   stable_q, stable_d;
  logic [NB-1:0][DB_W-1:0]         db_cnt_q, db_cnt_d;
  logic [1:0]                      af_lvl_q, af_lvl_d;
  logic [1:0][AF_W-1:0]            af_cnt_q, af_cnt_d;
  logic [1:0]                      fire_eff;
  logic [0:4]                      vec_a, vec_b;
  logic [0:4]                      joy1_d, joy2_d;
  logic                            changed_d;

  // Flatten both ports: bits 0..4 are port A, 5..9 are port B, each {fire,left,right,down,up}.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 5; i++) begin
      raw[i]     = joya_raw[i];
      raw[i + 5] = joyb_raw[i];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  assign tick = (ps_q == PS_W'(PRESCALE - 1));
  assign ps_d = tick ? '0 : ps_q + PS_W'(1);

  // A new level is accepted only after persisting across DEBOUNCE_TICKS consecutive ticks.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 10; i++) begin
      if (sync[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
          stable_d[i] = sync[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Autofire phase restarts asserted whenever fire is released or autofire is disabled.
  always_comb begin
    af_lvl_d = af_lvl_q;
    af_cnt_d = af_cnt_q;
    fire_eff = '0;
    for (int p = 0; p < 2; p++) begin
      if (!autofire_en[p] || stable_q[p * 5]) begin
        af_cnt_d[p] = '0;
        af_lvl_d[p] = 1'b1;
      end else if (tick) begin
        if (af_cnt_q[p] == AF_W'(AUTOFIRE_HALF - 1)) begin
          af_cnt_d[p] = '0;
          af_lvl_d[p] = ~af_lvl_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] + AF_W'(1);
        end
      end
      fire_eff[p] = ~stable_q[p * 5] & (autofire_en[p] ? af_lvl_q[p] : 1'b1);
    end
  end

  always_comb begin
    vec_a    = '0;
    vec_b    = '0;
    vec_a[0] = fire_eff[0];
    vec_b[0] = fire_eff[1];
    for (int k = 1; k < 5; k++) begin
      vec_a[k] = ~stable_q[k];
      vec_b[k] = ~stable_q[k + 5];
    end
    joy1_d    = swap ? vec_b : vec_a;
    joy2_d    = swap ? vec_a : vec_b;
    changed_d = ({joy1_d, joy2_d} != {joy1, joy2});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '1;
      ps_q     <= '0;
      stable_q <= '1;
      db_cnt_q <= '0;
      af_lvl_q <= '1;
      af_cnt_q <= '0;
      joy1     <= '0;
      joy2     <= '0;
      changed  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      ps_q     <= ps_d;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      af_lvl_q <= af_lvl_d;
      af_cnt_q <= af_cnt_d;
      joy1     <= joy1_d;
      joy2     <= joy2_d;
      changed  <= changed_d;
    end
  end

endmodule

// File: tb/tb_joystick_conditioner.sv
// Bench for joystick_conditioner: interval-arithmetic reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_joystick_conditioner;

  localparam int P  = 4;
  localparam int DT = 3;
  localparam int AH = 2;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [0:4] joya_raw = 5'b11111;
  logic [0:4] joyb_raw = 5'b11111;
  logic [1:0] autofire_en = 2'b00;
  logic       swap = 1'b0;
  logic [0:4] joy1;
  logic [0:4] joy2;
  logic       changed;

  int tests   = 0;
  int fails   = 0;
  int chg_cnt = 0;

  joystick_conditioner #(
    .SYNC_STAGES   (SS),
    .PRESCALE      (P),
    .DEBOUNCE_TICKS(DT),
    .AUTOFIRE_HALF (AH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joya_raw   (joya_raw),
    .joyb_raw   (joyb_raw),
    .autofire_en(autofire_en),
    .swap       (swap),
    .joy1       (joy1),
    .joy2       (joy2),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  // Reference model. Edge index m_n counts clock edges since reset release; the prescaler
  // ticks on edges with m_n % P == P-1, so tick counts over an interval are plain division.
  bit   [9:0] m_stable = '1;
  int         m_db_start [10];
  int         m_af_start [2];
  int         m_n = 0;
  bit   [9:0] m_hist [$];
  logic [0:4] exp_joy1 = '0;
  logic [0:4] exp_joy2 = '0;
  logic       exp_changed = 1'b0;

  always @(posedge clk or negedge reset_n) begin : model
    bit   [9:0] raw_v;
    bit   [9:0] sync_v;
    bit   [1:0] fire_v;
    logic [0:4] va, vb, j1, j2;
    bit         pressed, lvl;
    int         t;
    if (!reset_n) begin
      m_n = 0;
      m_hist.delete();
      m_stable = '1;
      for (int i = 0; i < 10; i++) m_db_start[i] = -1;
      m_af_start[0] = -1;
      m_af_start[1] = -1;
      exp_joy1 = '0;
      exp_joy2 = '0;
      exp_changed = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        raw_v[i]     = joya_raw[i];
        raw_v[i + 5] = joyb_raw[i];
      end
      sync_v = (m_hist.size() == SS) ? m_hist[0] : '1;
      m_hist.push_back(raw_v);
      if (m_hist.size() > SS) void'(m_hist.pop_front());
      for (int p = 0; p < 2; p++) begin
        pressed = !m_stable[p * 5];
        if (autofire_en[p] && pressed) begin
          if (m_af_start[p] < 0) m_af_start[p] = m_n;
          t   = m_n / P - m_af_start[p] / P;
          lvl = ((t / AH) % 2) == 0;
        end else begin
          m_af_start[p] = -1;
          lvl = 1'b1;
        end
        fire_v[p] = pressed && (autofire_en[p] ? lvl : 1'b1);
      end
      va[0] = fire_v[0];
      vb[0] = fire_v[1];
      for (int k = 1; k < 5; k++) begin
        va[k] = !m_stable[k];
        vb[k] = !m_stable[k + 5];
      end
      j1 = swap ? vb : va;
      j2 = swap ? va : vb;
      exp_changed = ({j1, j2} != {exp_joy1, exp_joy2});
      exp_joy1 = j1;
      exp_joy2 = j2;
      for (int i = 0; i < 10; i++) begin
        if (sync_v[i] != m_stable[i]) begin
          if (m_db_start[i] < 0) m_db_start[i] = m_n;
          if ((m_n + 1) / P - m_db_start[i] / P == DT) begin
            m_stable[i]   = sync_v[i];
            m_db_start[i] = -1;
          end
        end else begin
          m_db_start[i] = -1;
        end
      end
      m_n++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    tests++;
    if (joy1 !== exp_joy1 || joy2 !== exp_joy2 || changed !== exp_changed) begin
      fails++;
      $display("FAIL model_cmp @%0t: joy1=%b joy2=%b changed=%b, expected joy1=%b joy2=%b changed=%b",
               $time, joy1, joy2, changed, exp_joy1, exp_joy2, exp_changed);
    end
    if (changed === 1'b1) chg_cnt++;
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int k);
    repeat (k) cyc();
  endtask

  // Cycles until joy1 equals target (edge sampling the new raw counts as 1); 0 = timed out.
  task automatic wait_joy1(input logic [0:4] target, output int c);
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (joy1 === target) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic wait_fire(input logic lvl, output int c);
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      if (joy1[0] === lvl) begin
        c = i;
        break;
      end
      cyc();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c, c0, c1, lo, hi;
    logic [0:4] a, b;

    for (int i = 0; i < 100; i++) begin
      cyc();
      check("reset_hold", int'({joy1, joy2, changed}), 0);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    cycles(5);

    // Up press and release latency on port A.
    c0 = chg_cnt;
    joya_raw[4] = 1'b0;
    wait_joy1(5'b00001, c);
    check("up_press_latency_ok", int'(c >= 11 && c <= 15), 1);
    cycles(10);
    check("up_press_joy1", int'(joy1), 5'b00001);
    check("up_press_pulses", chg_cnt - c0, 1);
    c0 = chg_cnt;
    joya_raw[4] = 1'b1;
    wait_joy1(5'b00000, c);
    check("up_release_latency_ok", int'(c >= 11 && c <= 15), 1);
    cycles(10);
    check("up_release_pulses", chg_cnt - c0, 1);

    // Reset mid-operation clears outputs immediately; pending right press is lost.
    joya_raw[4] = 1'b0;
    wait_joy1(5'b00001, c);
    check("pre_reset_joy1", int'(joy1), 5'b00001);
    joya_raw[2] = 1'b0;
    cycles(6);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_joy1", int'(joy1), 0);
    check("midreset_joy2", int'(joy2), 0);
    check("midreset_changed", int'(changed), 0);
    joya_raw = 5'b11111;
    cycles(3);
    @(posedge clk);
    #2 reset_n = 1'b1;
    cycles(20);
    check("post_reset_joy1", int'(joy1), 0);

    // Bounce on left: 6 low, 2 high, then held low.
    hi = 0;
    joya_raw[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin cyc(); hi |= int'(joy1[1]); end
    joya_raw[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin cyc(); hi |= int'(joy1[1]); end
    check("bounce_no_assert", hi, 0);
    joya_raw[1] = 1'b0;
    wait_joy1(5'b01000, c);
    check("bounce_latency_ok", int'(c >= 11 && c <= 15), 1);
    joya_raw[1] = 1'b1;
    cycles(25);

    // Autofire on port A fire.
    autofire_en = 2'b01;
    joya_raw[0] = 1'b0;
    wait_fire(1'b1, c);
    check("af_first_rise_seen", int'(c != 0), 1);
    wait_fire(1'b0, c);
    c0 = chg_cnt;
    lo = 0;
    for (int i = 0; i < 30 && joy1[0] === 1'b0; i++) begin lo++; cyc(); end
    hi = 0;
    for (int i = 0; i < 30 && joy1[0] === 1'b1; i++) begin hi++; cyc(); end
    check("af_low_run", lo, 8);
    check("af_high_run", hi, 8);
    check("af_period_pulses", chg_cnt - c0, 2);
    joya_raw[0] = 1'b1;
    cycles(30);
    check("af_release_fire", int'(joy1[0]), 0);
    c1 = chg_cnt;
    cycles(20);
    check("af_release_quiet", chg_cnt - c1, 0);
    autofire_en = 2'b00;

    // Port swap with B left held.
    joyb_raw[1] = 1'b0;
    cycles(25);
    check("swap0_joy2", int'(joy2), 5'b01000);
    check("swap0_joy1", int'(joy1), 0);
    c0 = chg_cnt;
    swap = 1'b1;
    cyc();
    check("swap1_joy1", int'(joy1), 5'b01000);
    check("swap1_joy2", int'(joy2), 0);
    check("swap1_changed", int'(changed), 1);
    cyc();
    check("swap1_pulses", chg_cnt - c0, 1);
    swap = 1'b0;
    cyc();
    check("swapback_joy2", int'(joy2), 5'b01000);
    check("swapback_joy1", int'(joy1), 0);
    cyc();
    check("swapback_pulses", chg_cnt - c0, 2);
    joyb_raw[1] = 1'b1;
    cycles(25);

    // Simultaneous presses on both ports land on one cycle with one pulse.
    c0 = chg_cnt;
    joya_raw[4] = 1'b0;
    joyb_raw[3] = 1'b0;
    for (int i = 0; i < 30 && joy1 === 5'b00000 && joy2 === 5'b00000; i++) cyc();
    check("simul_joy1", int'(joy1), 5'b00001);
    check("simul_joy2", int'(joy2), 5'b00010);
    check("simul_changed", int'(changed), 1);
    cyc();
    check("simul_pulses", chg_cnt - c0, 1);
    joya_raw = 5'b11111;
    joyb_raw = 5'b11111;
    cycles(25);

    // Randomised traffic against the model, with one mid-run reset.
    for (int n = 0; n < 4000; n++) begin
      a = joya_raw;
      b = joyb_raw;
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(19) == 0) a[k] = ~a[k];
        if ($urandom_range(19) == 0) b[k] = ~b[k];
      end
      joya_raw = a;
      joyb_raw = b;
      if ($urandom_range(199) == 0) autofire_en = 2'($urandom_range(3));
      if ($urandom_range(99) == 0) swap = ~swap;
      if (n == 2000) begin
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rand_reset_out", int'({joy1, joy2, changed}), 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/joystick_conditioner.md
Name: joystick_conditioner

Overview:
- Conditions the raw, active-low Pmod joystick pins for both ports before they reach the mainboard joy1/joy2 inputs.
- Per bit, in order: synchroniser, tick-based debounce, optional fire autofire, port swap, registered active-high output.
- Also emits a one-cycle change strobe, usable by the service processor or an activity LED.
- Replaces the bare inversion currently done at the top level.

Parameters:
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain (≥2).
- PRESCALE, 1000, clk cycles per sample tick (≥1; 1 = tick every cycle).
- DEBOUNCE_TICKS, 8, consecutive ticks a new level must persist before acceptance (≥1).
- AUTOFIRE_HALF, 50, ticks per autofire half-period (≥1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- joya_raw  in  5  port A pins, active-low. Bit order [0:4] = {fire, left, right, down, up}.
- joyb_raw  in  5  port B pins, active-low, same order.
- autofire_en  in  2  [0] enables autofire on port A fire; [1] on port B fire.
- swap  in  1  1 = port A drives joy2 and port B drives joy1.
- joy1  out  5  conditioned joystick 1, active-high, order {fire, left, right, down, up}.
- joy2  out  5  conditioned joystick 2, active-high, same order.
- changed  out  1  one-cycle pulse when {joy1, joy2} differs from its previous registered value.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all synchroniser flops = 1 (released);
  - debounced state = 1 (released);
  - debounce and autofire counters = 0; prescaler = 0;
  - joy1 = joy2 = 0, changed = 0.
- Release is synchronous: first clk edge with reset_n high.
- Reset asserted mid-operation clears everything immediately. No pending press survives.
- Prescaler:
  - counts 0..PRESCALE-1, wraps to 0;
  - tick = 1 during the cycle the count equals PRESCALE-1.
- Debounce (each of the 10 bits independently):
  - sync = last synchroniser stage.
  - sync == stable: counter clears to 0 on any cycle.
  - sync != stable on a tick, counter < DEBOUNCE_TICKS-1: counter increments.
  - sync != stable on a tick, counter == DEBOUNCE_TICKS-1: stable <= sync, counter <= 0.
  - Any bounce back to the stable level before acceptance restarts the count.
- Autofire (per port p):
  - pressed = ~stable fire bit.
  - autofire_en[p] = 0 or not pressed: phase counter = 0, af_level = 1.
  - Otherwise, on each tick: counter increments; at AUTOFIRE_HALF-1 it wraps to 0 and af_level toggles.
  - Effective fire = pressed & (autofire_en[p] ? af_level : 1). The first autofire half-period is therefore asserted.
  - Toggling autofire_en while held: takes effect the next cycle; phase restarts at 1 when re-enabled.
- Output stage (registered, one cycle after debounced/autofire state):
  - vecA = {fireA_eff, ~stableA[1:4]}; vecB likewise.
  - joy1 <= swap ? vecB : vecA; joy2 <= swap ? vecA : vecB.
  - changed <= ({next joy1, next joy2} != {joy1, joy2}).
- Swap change: takes effect on the next registered update. Pulses changed only if outputs differ.
- Latency, raw edge to joy change: SYNC_STAGES + (DEBOUNCE_TICKS-1)·PRESCALE + 1 minimum; SYNC_STAGES + DEBOUNCE_TICKS·PRESCALE + 1 maximum.
- Simultaneous changes on multiple bits are debounced independently and may land on the same tick. Only one changed pulse is produced per cycle.
- Steady raw inputs produce no changed pulses, except autofire toggles, which pulse changed on every toggle.

Test Plan (PRESCALE=4, DEBOUNCE_TICKS=3, AUTOFIRE_HALF=2, SYNC_STAGES=2):
- Reset with all raw = 5'b11111 -> joy1 = joy2 = 0 and changed = 0, held for 100 cycles. Assert reset_n mid-count -> outputs 0 same cycle.
- Drive joya_raw[4] (up) low and hold -> joy1 = 5'b00001 within 11..15 cycles. Exactly one changed pulse. Release -> back to 0 with the same latency bound.
- Pulse joya_raw[1] low for 6 cycles, high 2, low 6 (bounce) -> joy1[1] never asserts. Hold low -> asserts ≤15 cycles after the last falling edge.
- autofire_en = 2'b01, hold joya fire low -> joy1[0] = 1 for 8 cycles, 0 for 8, repeating. changed pulses on every toggle. Release -> 0 after debounce, no further pulses.
- Port B left held (joy2 = 5'b01000), set swap = 1 -> next cycle joy1 = 5'b01000, joy2 = 0, one changed pulse. Clear swap -> restores, one pulse.
- Press A up and B down on the same cycle -> both outputs update on the same cycle, single changed pulse. joy1 = 5'b00001, joy2 = 5'b00010.
